imm_decode_stage: RTL
=====================

// Module: imm_decode_stage
// PURPOSE
//  Registered, handshaked immediate-generation stage between instruction fetch and decode/execute.
//  Extracts the immediate for the ImmSrc format and extends it to XLEN (RV32/RV64).
//  Also computes the PC-relative target PC+imm.
//  Skid buffer keeps full throughput with a registered IN_READY.
// PARAMETERS
//  XLEN  32  datapath width; legal values 32 or 64 only
//  SKID  1   1: 2-entry skid buffer, IN_READY driven from a flop; 0: single register, IN_READY combinational
// PORTS
//  CLK         in   1     clock, all state updates on rising edge
//  RST_N       in   1     synchronous active-low reset
//  FLUSH       in   1     synchronous squash of all held entries
//  IN_VALID    in   1     upstream entry valid
//  IN_READY    out  1     stage can accept an entry this cycle
//  IN_INSTR    in   32    raw instruction word
//  IN_IMMSRC   in   3     format select; encodings from type.h (Rtype..SYSTEM)
//  IN_PC       in   XLEN  PC of IN_INSTR
//  OUT_VALID   out  1     output entry valid
//  OUT_READY   in   1     downstream accepts
//  OUT_INSTR   out  32    instruction passed through
//  OUT_PC      out  XLEN  PC passed through
//  OUT_IMM     out  XLEN  extended immediate
//  OUT_TARGET  out  XLEN  OUT_PC + OUT_IMM, modulo 2^XLEN
//  OUT_BADSRC  out  1     IN_IMMSRC was not a defined encoding
// BEHAVIOUR
//  Reset (RST_N=0 at an edge)
//   - OUT_VALID=0; OUT_BADSRC=0; all payload outputs 0.
//   - Skid entry cleared; IN_READY=0 while RST_N=0, 1 the cycle after release.
//   - Reset mid-transfer discards everything.
//  Transfers
//   - Input transfer on IN_VALID&IN_READY; output transfer on OUT_VALID&OUT_READY.
//   - Latency exactly 1 cycle from input transfer to OUT_VALID.
//   - While OUT_VALID=1 and OUT_READY=0, all OUT_* hold stable.
//  Immediate extraction (computed before the register)
//   - Rtype: shamt zero-extended; Instr[24:20] for XLEN=32, Instr[25:20] for XLEN=64.
//   - Itype/Stype/Btype/Jtype/Utype: standard RISC-V bit placement, sign-extended from Instr[31] to XLEN.
//   - Btype/Jtype bit 0 = 0; Utype low 12 bits = 0.
//   - SYSTEM: Instr[19:15] zero-extended.
//   - Undefined ImmSrc: imm=0, OUT_BADSRC=1, entry still passed through.
//  Target: plain XLEN-bit add, carry discarded (wraps at 2^XLEN); computed for every format.
//  SKID=1: main reg + skid reg; IN_READY = !skid_valid (registered).
//   - Accept while main holds and OUT_READY=0 -> entry goes to skid.
//   - Next output transfer moves skid to main.
//   - Order is strictly FIFO.
//  SKID=0: IN_READY = !OUT_VALID | OUT_READY.
//  Simultaneous events
//   - Accept+emit same cycle: new entry replaces main, no bubble.
//   - FLUSH beats both: same-cycle input is dropped, both entries cleared.
//   - After FLUSH: OUT_VALID=0 next cycle; IN_READY=1 next cycle.
// STRUCTURE
//  - ImmSrc encodings stay in type.h; add XLEN-legal-value constants there.
//  - One combinational sub-module imm_extract (Instr, ImmSrc -> imm, badsrc), parametrised by XLEN.
//  - Handshake/skid logic and target adder live in this module.
// TESTING
//  1 XLEN=32, Itype 0xFFF00093, PC 0x0 -> OUT_IMM 0xFFFFFFFF, TARGET 0xFFFFFFFF, valid 1 cycle later.
//  2 Btype 0xFE000EE3, PC 0x100 -> IMM 0xFFFFFFFC, TARGET 0x000000FC; Jtype 0x0080006F, PC 0xFFFFFFFC -> IMM 8, TARGET 0x4 (wrap).
//  3 XLEN=64: Utype 0x80000037 -> IMM 0xFFFFFFFF80000000; Rtype 0x03F09093 -> IMM 0x3F (6-bit shamt).
//  4 SKID=1, OUT_READY=0, push 3 back-to-back -> accepts 2, IN_READY=0 on 3rd; release -> FIFO order, no loss/duplication.
//  5 Stream 100 random entries, random OUT_READY -> scoreboard vs golden model; throughput 1/cycle with OUT_READY=1.
//  6 FLUSH and RST_N=0 each asserted with both entries full plus IN_VALID=1 -> OUT_VALID=0 next cycle, input dropped; undefined ImmSrc -> BADSRC=1, IMM=0.

Source files
------------

// File: rtl/imm_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// imm_decode_stage_pkg
//   Shared definitions for the immediate-generation stage: ImmSrc format
//   encodings, the legal XLEN values and a helper that tells whether an ImmSrc
//   code is one of the defined formats.
// -----------------------------------------------------------------------------
package imm_decode_stage_pkg;

    localparam int IMMSRC_W  = 3;
    localparam int INSTR_W   = 32;

    // Legal datapath widths.
    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

    // Immediate format select. Code 3'd7 is not a defined format.
    typedef enum logic [IMMSRC_W-1:0] {
        IMM_R   = 3'd0,   // shift amount
        IMM_I   = 3'd1,
        IMM_S   = 3'd2,
        IMM_B   = 3'd3,
        IMM_U   = 3'd4,
        IMM_J   = 3'd5,
        IMM_SYS = 3'd6    // CSR uimm in rs1 field
    } imm_src_e;

    function automatic logic imm_src_defined(input logic [IMMSRC_W-1:0] src);
        return (src <= IMM_SYS);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// -----------------------------------------------------------------------------
// imm_decode_stage_if
//   Upstream (fetch -> stage) and downstream (stage -> decode) handshake bus.
//   master : the environment side (drives in_*, out_ready)
//   slave  : the stage itself (drives in_ready, out_*)
// -----------------------------------------------------------------------------
interface imm_decode_stage_if
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
);
    // upstream
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic [IMMSRC_W-1:0] in_immsrc;
    logic [XLEN-1:0]     in_pc;
    // downstream
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_imm;
    logic [XLEN-1:0]     out_target;
    logic                out_badsrc;

    modport master (
        output in_valid, in_instr, in_immsrc, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_badsrc
    );

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_badsrc
    );
endinterface

// File: rtl/imm_decode_stage_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
//   Combinational immediate extraction and extension to XLEN.
//   instr_i  : raw 32-bit instruction
//   immsrc_i : format select (imm_src_e)
//   imm_o    : extended immediate, 0 for an undefined format
//   badsrc_o : immsrc_i is not a defined format
// -----------------------------------------------------------------------------
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [IMMSRC_W-1:0] immsrc_i,
    output logic [XLEN-1:0]     imm_o,
    output logic                badsrc_o
);

    // 32-bit immediate with the sign already replicated for signed formats;
    // widening to XLEN is a separate step so one table covers RV32 and RV64.
    logic [31:0] raw;
    logic        sext;
    logic        shamt_hi;

    // Opcode bits carry no immediate information in any format.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    // RV64 shift amounts are 6 bits wide, RV32 only 5.
    assign shamt_hi = (XLEN == XLEN_RV64) ? instr_i[25] : 1'b0;

    always_comb begin
        raw      = '0;
        sext     = 1'b0;
        badsrc_o = !imm_src_defined(immsrc_i);
        case (imm_src_e'(immsrc_i))
            IMM_R:   raw = {26'd0, shamt_hi, instr_i[24:20]};
            IMM_I: begin
                raw  = {{20{instr_i[31]}}, instr_i[31:20]};
                sext = 1'b1;
            end
            IMM_S: begin
                raw  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                sext = 1'b1;
            end
            IMM_B: begin
                raw  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
                sext = 1'b1;
            end
            IMM_U: begin
                raw  = {instr_i[31:12], 12'd0};
                sext = 1'b1;
            end
            IMM_J: begin
                raw  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
                sext = 1'b1;
            end
            IMM_SYS: raw = {27'd0, instr_i[19:15]};
            default: raw = '0;
        endcase
    end

    assign imm_o = sext ? XLEN'($signed(raw)) : XLEN'(raw);

endmodule

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//   Registered, handshaked immediate-generation stage between fetch and
//   decode. Extracts and extends the immediate, computes PC+imm, and passes
//   instruction and PC through with a fixed 1-cycle latency.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   flush : synchronous squash of every held entry and of the same-cycle input
//   bus   : imm_decode_stage_if.slave (in_* upstream, out_* downstream)
//   SKID=1: main + skid register, in_ready comes straight from a flop.
//   SKID=0: single register, in_ready = !out_valid | out_ready.
// -----------------------------------------------------------------------------
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32,   // 32 or 64
    parameter int SKID = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_decode_stage_if.slave   bus
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    target;
        logic               bad;
    } entry_t;

    logic [XLEN-1:0] ext_imm;
    logic            ext_bad;
    entry_t          in_ent;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   in_ready_q, in_ready_d;

    logic   in_fire;
    logic   out_fire;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i  (bus.in_instr),
        .immsrc_i (bus.in_immsrc),
        .imm_o    (ext_imm),
        .badsrc_o (ext_bad)
    );

    // Target is computed ahead of the register so every output is a flop;
    // the add simply wraps at 2^XLEN.
    always_comb begin
        in_ent        = '0;
        in_ent.instr  = bus.in_instr;
        in_ent.pc     = bus.in_pc;
        in_ent.imm    = ext_imm;
        in_ent.target = bus.in_pc + ext_imm;
        in_ent.bad    = ext_bad;
    end

    if (SKID != 0) begin : g_rdy_reg
        assign bus.in_ready = in_ready_q;
    end else begin : g_rdy_comb
        assign bus.in_ready = rst_n & (~main_vld_q | bus.out_ready);
    end

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = main_vld_q & bus.out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            // Flush wins over both handshakes; a same-cycle input is lost.
            main_d     = '0;
            skid_d     = '0;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // in_ready is low while the skid is occupied, so only drain here.
            if (out_fire) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_vld_q || out_fire) begin
                // Empty main or same-cycle emit: new entry lands in main, no bubble.
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_ent;
                skid_vld_d = 1'b1;
            end
        end else if (out_fire) begin
            main_vld_d = 1'b0;
        end
        if (SKID == 0) begin
            skid_vld_d = 1'b0;
        end
        in_ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.out_valid  = main_vld_q;
    assign bus.out_instr  = main_q.instr;
    assign bus.out_pc     = main_q.pc;
    assign bus.out_imm    = main_q.imm;
    assign bus.out_target = main_q.target;
    assign bus.out_badsrc = main_q.bad;

endmodule
